// File: rtl/reg_wb_ctrl_if.sv
// Register-file writeback bus: pipeline result, slow-load issue/return, and the
// registered write port with the pending-destination scoreboard.
interface reg_wb_ctrl_if;
    logic [2:0]  pipe_op;
    logic [2:0]  pipe_addr;
    logic [15:0] pipe_data;
    logic        ld_issue;
    logic [2:0]  ld_issue_op;
    logic [2:0]  ld_issue_addr;
    logic        issue_ok;
    logic        ld_valid;
    logic        ld_ready;
    logic [2:0]  ld_op;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [2:0]  reg_op;
    logic [11:0] pend_mask;
    logic        err;

    modport master (
        output pipe_op, pipe_addr, pipe_data,
        output ld_issue, ld_issue_op, ld_issue_addr,
        output ld_valid, ld_op, ld_addr, ld_data,
        input  issue_ok, ld_ready, wb_addr, wb_data, reg_op, pend_mask, err
    );

    modport slave (
        input  pipe_op, pipe_addr, pipe_data,
        input  ld_issue, ld_issue_op, ld_issue_addr,
        input  ld_valid, ld_op, ld_addr, ld_data,
        output issue_ok, ld_ready, wb_addr, wb_data, reg_op, pend_mask, err
    );
endinterface

// File: rtl/reg_wb_ctrl.sv
// Register-file writer: pipeline results take priority, slow load results are
// buffered in a small FIFO, and a scoreboard tracks destinations of issued loads.
module reg_wb_ctrl #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned MAX_PEND   = 2
) (
    input logic          clk_50MHz,
    input logic          rst,
    reg_wb_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_REG = 3'd1,
        OP_T   = 3'd2,
        OP_SP  = 3'd3,
        OP_IH  = 3'd4,
        OP_RA  = 3'd5
    } wb_op_e;

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    // One-hot scoreboard bit for a destination; zero for NOP and unused codes.
    function automatic logic [11:0] dest_mask(input logic [2:0] op, input logic [2:0] addr);
        logic [11:0] m;
        m = '0;
        case (op)
            OP_REG:  m[addr] = 1'b1;
            OP_T:    m[8]    = 1'b1;
            OP_SP:   m[9]    = 1'b1;
            OP_IH:   m[10]   = 1'b1;
            OP_RA:   m[11]   = 1'b1;
            default: m       = '0;
        endcase
        return m;
    endfunction

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [2:0]    f_op   [FIFO_DEPTH];
    logic [2:0]    f_addr [FIFO_DEPTH];
    logic [15:0]   f_data [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;

    logic [2:0]  reg_op_q, wb_addr_q;
    logic [15:0] wb_data_q;
    logic [11:0] pend_q;
    logic        err_q;

    logic        fifo_empty, fifo_full, ld_ready, issue_ok;
    logic        pipe_wr, hs, ld_good, pop, bypass, push, err_ev;
    logic [11:0] pipe_dm, ld_dm, iss_dm, head_dm, pend_set, pend_clr;
    logic [2:0]  wr_op, wr_addr;
    logic [15:0] wr_data;

    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == CW'(FIFO_DEPTH));
        ld_ready   = rst & ~fifo_full;

        pipe_dm = dest_mask(bus.pipe_op, bus.pipe_addr);
        ld_dm   = dest_mask(bus.ld_op, bus.ld_addr);
        iss_dm  = dest_mask(bus.ld_issue_op, bus.ld_issue_addr);
        head_dm = dest_mask(f_op[rd_ptr], f_addr[rd_ptr]);

        issue_ok = rst & (iss_dm != '0) & ((iss_dm & pend_q) == '0)
                   & ($countones(pend_q) < MAX_PEND);

        // Results whose destination is not pending are dropped at acceptance.
        pipe_wr = (bus.pipe_op != OP_NOP);
        hs      = bus.ld_valid & ld_ready;
        ld_good = |(ld_dm & pend_q);
        pop     = ~pipe_wr & ~fifo_empty;
        bypass  = ~pipe_wr & fifo_empty & hs & ld_good;
        push    = hs & ld_good & ~bypass;

        wr_op    = OP_NOP;
        wr_addr  = wb_addr_q;
        wr_data  = wb_data_q;
        pend_clr = '0;
        if (pipe_wr) begin
            wr_op   = bus.pipe_op;
            wr_addr = bus.pipe_addr;
            wr_data = bus.pipe_data;
        end else if (pop) begin
            wr_op    = f_op[rd_ptr];
            wr_addr  = f_addr[rd_ptr];
            wr_data  = f_data[rd_ptr];
            pend_clr = head_dm;
        end else if (bypass) begin
            wr_op    = bus.ld_op;
            wr_addr  = bus.ld_addr;
            wr_data  = bus.ld_data;
            pend_clr = ld_dm;
        end

        pend_set = (bus.ld_issue & issue_ok) ? iss_dm : '0;
        err_ev   = (bus.ld_issue & ~issue_ok) | (hs & ~ld_good) | (pipe_wr & |(pipe_dm & pend_q));
    end

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            reg_op_q  <= OP_NOP;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            pend_q    <= '0;
            err_q     <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            reg_op_q  <= wr_op;
            wb_addr_q <= wr_addr;
            wb_data_q <= wr_data;
            pend_q    <= (pend_q & ~pend_clr) | pend_set;
            err_q     <= err_q | err_ev;
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (push) begin
            f_op[wr_ptr]   <= bus.ld_op;
            f_addr[wr_ptr] <= bus.ld_addr;
            f_data[wr_ptr] <= bus.ld_data;
        end
    end

    assign bus.issue_ok  = issue_ok;
    assign bus.ld_ready  = ld_ready;
    assign bus.reg_op    = reg_op_q;
    assign bus.wb_addr   = wb_addr_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.pend_mask = pend_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Bench for reg_wb_ctrl: directed vector table, reset/error sequences, and
// random traffic compared against a queue-based reference model.
module tb_reg_wb_ctrl;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned MAX_PEND   = 2;

    logic clk_50MHz = 1'b0;
    logic rst;
    always #10 clk_50MHz = ~clk_50MHz;

    reg_wb_ctrl_if bus ();

    reg_wb_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_PEND(MAX_PEND)) dut (
        .clk_50MHz(clk_50MHz),
        .rst      (rst),
        .bus      (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        bus.pipe_op = 0; bus.pipe_addr = 0; bus.pipe_data = 0;
        bus.ld_issue = 0; bus.ld_issue_op = 0; bus.ld_issue_addr = 0;
        bus.ld_valid = 0; bus.ld_op = 0; bus.ld_addr = 0; bus.ld_data = 0;
    endtask

    // Directed vectors: inputs for rep cycles, then expected outputs.
    typedef struct {
        logic [2:0] p_op; logic [2:0] p_addr; logic [15:0] p_data;
        logic iss; logic [2:0] i_op; logic [2:0] i_addr;
        logic lv; logic [2:0] l_op; logic [2:0] l_addr; logic [15:0] l_data;
        int rep;
        logic x_ok; logic x_rdy; logic [2:0] x_op; logic [2:0] x_addr; logic [15:0] x_data;
        logic [11:0] x_pend; logic x_err;
    } vec_t;

    // Reference model.
    typedef struct { logic [2:0] op; logic [2:0] addr; logic [15:0] data; } res_t;
    res_t        m_q[$];
    bit   [11:0] m_pend;
    bit          m_err, m_ok, m_rdy, m_hs;
    logic [2:0]  e_op, e_addr;
    logic [15:0] e_data;

    function automatic int dest(input logic [2:0] op, input logic [2:0] addr);
        case (op)
            3'd1:    return int'(addr);
            3'd2:    return 8;
            3'd3:    return 9;
            3'd4:    return 10;
            3'd5:    return 11;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pend = '0; m_err = 0;
        e_op = 0; e_addr = 0; e_data = 0;
    endtask

    task automatic model_step();
        int di, dl, dp;
        bit good, used;
        bit [11:0] np;
        res_t r;
        di = dest(bus.ld_issue_op, bus.ld_issue_addr);
        dl = dest(bus.ld_op, bus.ld_addr);
        m_ok  = (di >= 0) && !m_pend[di] && ($countones(m_pend) < MAX_PEND);
        m_rdy = (m_q.size() < FIFO_DEPTH);
        m_hs  = bus.ld_valid && m_rdy;
        good  = m_hs && (dl >= 0) && m_pend[dl];
        if (bus.ld_issue && !m_ok) m_err = 1;
        if (m_hs && !good) m_err = 1;
        np = m_pend;
        used = 0;
        if (bus.pipe_op != 0) begin
            dp = dest(bus.pipe_op, bus.pipe_addr);
            if (dp >= 0 && m_pend[dp]) m_err = 1;
            e_op = bus.pipe_op; e_addr = bus.pipe_addr; e_data = bus.pipe_data;
        end else if (m_q.size() > 0) begin
            r = m_q.pop_front();
            e_op = r.op; e_addr = r.addr; e_data = r.data;
            np[dest(r.op, r.addr)] = 0;
        end else if (good) begin
            e_op = bus.ld_op; e_addr = bus.ld_addr; e_data = bus.ld_data;
            np[dl] = 0;
            used = 1;
        end else begin
            e_op = 0;
        end
        if (good && !used) m_q.push_back('{bus.ld_op, bus.ld_addr, bus.ld_data});
        if (bus.ld_issue && m_ok) np[di] = 1;
        m_pend = np;
    endtask

    vec_t vecs[$];
    res_t inflight[$];
    res_t cur;
    bit   hold, from_inf;

    initial begin
        vecs.push_back('{3'd1,3'd3,16'h1234, 1'b0,3'd0,3'd0, 1'b0,3'd0,3'd0,16'h0000, 1, 1'b0,1'b1, 3'd1,3'd3,16'h1234, 12'h000,1'b0});
        vecs.push_back('{3'd0,3'd0,16'h0000, 1'b0,3'd0,3'd0, 1'b0,3'd0,3'd0,16'h0000, 1, 1'b0,1'b1, 3'd0,3'd0,16'h0000, 12'h000,1'b0});
        vecs.push_back('{3'd0,3'd0,16'h0000, 1'b1,3'd3,3'd0, 1'b0,3'd0,3'd0,16'h0000, 1, 1'b1,1'b1, 3'd0,3'd0,16'h0000, 12'h200,1'b0});
        vecs.push_back('{3'd0,3'd0,16'h0000, 1'b0,3'd0,3'd0, 1'b0,3'd0,3'd0,16'h0000, 9, 1'b0,1'b1, 3'd0,3'd0,16'h0000, 12'h200,1'b0});
        vecs.push_back('{3'd0,3'd0,16'h0000, 1'b0,3'd0,3'd0, 1'b1,3'd3,3'd0,16'hBEEF, 1, 1'b0,1'b1, 3'd3,3'd0,16'hBEEF, 12'h000,1'b0});
        vecs.push_back('{3'd0,3'd0,16'h0000, 1'b0,3'd0,3'd0, 1'b0,3'd0,3'd0,16'h0000, 1, 1'b0,1'b1, 3'd0,3'd0,16'h0000, 12'h000,1'b0});
        vecs.push_back('{3'd0,3'd0,16'h0000, 1'b1,3'd1,3'd1, 1'b0,3'd0,3'd0,16'h0000, 1, 1'b1,1'b1, 3'd0,3'd0,16'h0000, 12'h002,1'b0});
        vecs.push_back('{3'd0,3'd0,16'h0000, 1'b1,3'd1,3'd2, 1'b0,3'd0,3'd0,16'h0000, 1, 1'b1,1'b1, 3'd0,3'd0,16'h0000, 12'h006,1'b0});
        vecs.push_back('{3'd1,3'd4,16'h0004, 1'b0,3'd0,3'd0, 1'b1,3'd1,3'd1,16'h1111, 1, 1'b0,1'b1, 3'd1,3'd4,16'h0004, 12'h006,1'b0});
        vecs.push_back('{3'd1,3'd5,16'h0005, 1'b0,3'd0,3'd0, 1'b1,3'd1,3'd2,16'h2222, 1, 1'b0,1'b1, 3'd1,3'd5,16'h0005, 12'h006,1'b0});
        vecs.push_back('{3'd1,3'd6,16'h0006, 1'b0,3'd0,3'd0, 1'b0,3'd0,3'd0,16'h0000, 1, 1'b0,1'b0, 3'd1,3'd6,16'h0006, 12'h006,1'b0});
        vecs.push_back('{3'd1,3'd7,16'h0007, 1'b0,3'd0,3'd0, 1'b0,3'd0,3'd0,16'h0000, 2, 1'b0,1'b0, 3'd1,3'd7,16'h0007, 12'h006,1'b0});
        vecs.push_back('{3'd0,3'd0,16'h0000, 1'b0,3'd0,3'd0, 1'b0,3'd0,3'd0,16'h0000, 1, 1'b0,1'b0, 3'd1,3'd1,16'h1111, 12'h004,1'b0});
        vecs.push_back('{3'd0,3'd0,16'h0000, 1'b0,3'd0,3'd0, 1'b0,3'd0,3'd0,16'h0000, 1, 1'b0,1'b1, 3'd1,3'd2,16'h2222, 12'h000,1'b0});
        vecs.push_back('{3'd0,3'd0,16'h0000, 1'b0,3'd0,3'd0, 1'b0,3'd0,3'd0,16'h0000, 1, 1'b0,1'b1, 3'd0,3'd0,16'h0000, 12'h000,1'b0});
        vecs.push_back('{3'd0,3'd0,16'h0000, 1'b1,3'd1,3'd1, 1'b0,3'd0,3'd0,16'h0000, 1, 1'b1,1'b1, 3'd0,3'd0,16'h0000, 12'h002,1'b0});
        vecs.push_back('{3'd0,3'd0,16'h0000, 1'b1,3'd2,3'd0, 1'b0,3'd0,3'd0,16'h0000, 1, 1'b1,1'b1, 3'd0,3'd0,16'h0000, 12'h102,1'b0});
        vecs.push_back('{3'd0,3'd0,16'h0000, 1'b1,3'd1,3'd5, 1'b0,3'd0,3'd0,16'h0000, 1, 1'b0,1'b1, 3'd0,3'd0,16'h0000, 12'h102,1'b1});

        // Reset state, with handshake/issue inputs asserted to check gating.
        rst = 1'b0;
        set_idle();
        bus.ld_issue_op = 3'd1; bus.ld_valid = 1'b1; bus.ld_op = 3'd1;
        repeat (3) @(negedge clk_50MHz);
        chk("rst reg_op", bus.reg_op, 0);
        chk("rst wb_addr", bus.wb_addr, 0);
        chk("rst wb_data", bus.wb_data, 0);
        chk("rst pend", bus.pend_mask, 0);
        chk("rst err", bus.err, 0);
        chk("rst ld_ready", bus.ld_ready, 0);
        chk("rst issue_ok", bus.issue_ok, 0);
        set_idle();
        rst = 1'b1;

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].rep; r++) begin
                @(negedge clk_50MHz);
                bus.pipe_op = vecs[i].p_op; bus.pipe_addr = vecs[i].p_addr; bus.pipe_data = vecs[i].p_data;
                bus.ld_issue = vecs[i].iss; bus.ld_issue_op = vecs[i].i_op; bus.ld_issue_addr = vecs[i].i_addr;
                bus.ld_valid = vecs[i].lv; bus.ld_op = vecs[i].l_op; bus.ld_addr = vecs[i].l_addr; bus.ld_data = vecs[i].l_data;
                #1;
                chk($sformatf("vec%0d issue_ok", i), bus.issue_ok, vecs[i].x_ok);
                chk($sformatf("vec%0d ld_ready", i), bus.ld_ready, vecs[i].x_rdy);
                @(posedge clk_50MHz); #1;
                chk($sformatf("vec%0d reg_op", i), bus.reg_op, vecs[i].x_op);
                if (vecs[i].x_op == 3'd1) chk($sformatf("vec%0d wb_addr", i), bus.wb_addr, vecs[i].x_addr);
                if (vecs[i].x_op != 3'd0) chk($sformatf("vec%0d wb_data", i), bus.wb_data, vecs[i].x_data);
                chk($sformatf("vec%0d pend", i), bus.pend_mask, vecs[i].x_pend);
                chk($sformatf("vec%0d err", i), bus.err, vecs[i].x_err);
            end
        end

        // Fill the FIFO behind a busy pipe, then reset asynchronously mid-write.
        @(negedge clk_50MHz); set_idle(); rst = 1'b0;
        @(negedge clk_50MHz); rst = 1'b1;
        bus.ld_issue = 1; bus.ld_issue_op = 3'd1; bus.ld_issue_addr = 3'd1;
        @(negedge clk_50MHz); bus.ld_issue_addr = 3'd2;
        @(negedge clk_50MHz); bus.ld_issue = 0; bus.ld_issue_op = 0;
        bus.pipe_op = 3'd1; bus.pipe_addr = 3'd1; bus.pipe_data = 16'h00A1;
        bus.ld_valid = 1; bus.ld_op = 3'd1; bus.ld_addr = 3'd1; bus.ld_data = 16'h0111;
        @(negedge clk_50MHz);
        bus.pipe_addr = 3'd6; bus.pipe_data = 16'h00A6;
        bus.ld_addr = 3'd2; bus.ld_data = 16'h0222;
        @(posedge clk_50MHz); #1;
        chk("full err", bus.err, 1);
        chk("full pend", bus.pend_mask, 12'h006);
        chk("full ld_ready", bus.ld_ready, 0);
        chk("full wb_addr", bus.wb_addr, 6);
        @(negedge clk_50MHz);
        bus.ld_valid = 0; bus.pipe_addr = 3'd7; bus.pipe_data = 16'h00A7;
        bus.ld_issue_op = 3'd3; bus.ld_issue_addr = 3'd0;
        @(posedge clk_50MHz); #1;
        chk("pre-rst reg_op", bus.reg_op, 1);
        #4 rst = 1'b0;
        #1;
        chk("async rst reg_op", bus.reg_op, 0);
        chk("async rst pend", bus.pend_mask, 0);
        chk("async rst err", bus.err, 0);
        chk("async rst ld_ready", bus.ld_ready, 0);
        chk("async rst issue_ok", bus.issue_ok, 0);
        @(negedge clk_50MHz); set_idle(); rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk_50MHz); #1;
            chk($sformatf("post-rst drain%0d reg_op", k), bus.reg_op, 0);
            chk($sformatf("post-rst drain%0d ld_ready", k), bus.ld_ready, 1);
        end

        // Result for a destination never issued: dropped, sticky error.
        @(negedge clk_50MHz);
        bus.ld_valid = 1; bus.ld_op = 3'd5; bus.ld_addr = 3'd0; bus.ld_data = 16'hDEAD;
        @(posedge clk_50MHz); #1;
        chk("unissued reg_op", bus.reg_op, 0);
        chk("unissued err", bus.err, 1);
        chk("unissued pend", bus.pend_mask, 0);
        @(negedge clk_50MHz); set_idle();
        @(posedge clk_50MHz); #1;
        chk("err sticky", bus.err, 1);

        // Random traffic against the reference model.
        @(negedge clk_50MHz); rst = 1'b0;
        @(negedge clk_50MHz); rst = 1'b1;
        model_reset();
        hold = 0; from_inf = 0; inflight.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_50MHz);
            if (cyc % 600 == 599) begin
                set_idle();
                rst = 1'b0;
                #1;
                chk("rand rst reg_op", bus.reg_op, 0);
                chk("rand rst pend", bus.pend_mask, 0);
                model_reset();
                hold = 0; inflight.delete();
                @(negedge clk_50MHz);
                rst = 1'b1;
            end
            set_idle();
            if ($urandom_range(9) < 4) begin
                bus.pipe_op = 3'($urandom_range(5, 1));
                bus.pipe_addr = 3'($urandom); bus.pipe_data = 16'($urandom);
            end
            if ($urandom_range(3) == 0) begin
                bus.ld_issue = 1;
                bus.ld_issue_op = 3'($urandom_range(5)); bus.ld_issue_addr = 3'($urandom);
            end
            if (!hold) begin
                if (inflight.size() > 0 && $urandom_range(2) == 0) begin
                    cur = inflight[0]; cur.data = 16'($urandom);
                    from_inf = 1; hold = 1;
                end else if ($urandom_range(39) == 0) begin
                    cur.op = 3'($urandom_range(5)); cur.addr = 3'($urandom); cur.data = 16'($urandom);
                    from_inf = 0; hold = 1;
                end
            end
            bus.ld_valid = hold; bus.ld_op = cur.op; bus.ld_addr = cur.addr; bus.ld_data = cur.data;
            model_step();
            #1;
            chk("rand issue_ok", bus.issue_ok, m_ok);
            chk("rand ld_ready", bus.ld_ready, m_rdy);
            if (m_hs) begin
                hold = 0;
                if (from_inf) void'(inflight.pop_front());
            end
            if (bus.ld_issue && m_ok) inflight.push_back('{bus.ld_issue_op, bus.ld_issue_addr, 16'h0});
            @(posedge clk_50MHz); #1;
            chk("rand reg_op", bus.reg_op, e_op);
            if (e_op == 3'd1) chk("rand wb_addr", bus.wb_addr, e_addr);
            if (e_op != 3'd0) chk("rand wb_data", bus.wb_data, e_data);
            chk("rand pend", bus.pend_mask, m_pend);
            chk("rand err", bus.err, m_err);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
